// File: rtl/data_memory_arbiter.sv
// Arbiter sharing the single-port data memory between the pipeline MEM
// stage and a debug/loader port. The MEM stage has priority; a starvation
// guard forces one debug slot after MAX_WAIT lost cycles. Read data is
// routed back to the owner of the access one cycle after the grant.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [31:0]       pipe_addr,
  input  logic [31:0]       pipe_wdata,
  output logic              pipe_stall,
  output logic [31:0]       pipe_rdata,
  output logic              pipe_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Counter is kept at least one bit wide so MAX_WAIT = 0 still elaborates;
  // in that case it never leaves zero and every debug request is forced.
  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e          rd_owner_q, rd_owner_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            force_dbg;
  logic            dbg_win;
  logic            pipe_win;
  logic [ADDR_W-1:0] pipe_word;
  logic            unused_addr_bits;

  assign pipe_word        = pipe_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{pipe_addr[31:ADDR_W+2], pipe_addr[1:0]};

  // Combinational grant, memory-side mux and next-state for owner/counter.
  always_comb begin
    force_dbg  = dbg_req & (wait_cnt_q == WAIT_MAX);
    dbg_win    = force_dbg | (dbg_req & ~pipe_req);
    pipe_win   = pipe_req & ~dbg_win;
    dbg_gnt    = dbg_win;
    pipe_stall = pipe_req & dbg_win;
    mem_en     = pipe_req | dbg_req;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (pipe_req) begin
      mem_we    = pipe_we;
      mem_addr  = pipe_word;
      mem_wdata = pipe_wdata;
    end

    rd_owner_d = OWN_NONE;
    if (pipe_win && !pipe_we) begin
      rd_owner_d = OWN_PIPE;
    end else if (dbg_win && !dbg_we) begin
      rd_owner_d = OWN_DBG;
    end

    wait_cnt_d = '0;
    if (dbg_req && !dbg_win) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // Owner and starvation counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Read-data steering to the owner of last cycle's read.
  always_comb begin
    pipe_rvalid = (rd_owner_q == OWN_PIPE);
    dbg_rvalid  = (rd_owner_q == OWN_DBG);
    pipe_rdata  = pipe_rvalid ? mem_rdata : '0;
    dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;
  end

endmodule
